// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - data-side SRAM responder for the MEM stage
//
// Purpose:
//   Takes one word-addressed load/store request from the MEM stage and runs it
//   against a single-port synchronous SRAM with WAIT_CYCLES extra read latency.
//   The pipeline is held with stall_o until the access reaches DONE, where the
//   full 32-bit read word is presented on ram_data_o.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ram_en_i          request valid (held stable by MEM while stalled)
//   mem_write_en_i    1 = store, 0 = load
//   mem_addr_i        byte address; bits [ADDR_W+1:2] form the SRAM word address
//   mem_select_i      byte lanes, bit3 = data[31:24] .. bit0 = data[7:0]
//   store_data_i      lane-replicated store data
//   ram_data_o        read word (meaningful in DONE)
//   stall_o           pipeline hold
//   sram_en_o         SRAM chip enable, single-cycle pulse in ISSUE
//   sram_we_o         SRAM byte write enables (same lane mapping as mem_select_i)
//   sram_addr_o       SRAM word address
//   sram_wdata_o      SRAM write data
//   sram_rdata_i      SRAM read data, valid WAIT_CYCLES+1 cycles after sram_en_o

module data_ram_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_en_i,
    input  logic              mem_write_en_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [3:0]        mem_select_i,
    input  logic [31:0]       store_data_i,
    output logic [31:0]       ram_data_o,
    output logic              stall_o,
    output logic              sram_en_o,
    output logic [3:0]        sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]        state_q,      state_d;
    logic [3:0]        cnt_q,        cnt_d;
    logic [ADDR_W-1:0] req_addr_q,   req_addr_d;
    logic              req_we_q,     req_we_d;
    logic [3:0]        req_sel_q,    req_sel_d;
    logic [31:0]       req_data_q,   req_data_d;
    logic [31:0]       rdata_q,      rdata_d;
    // Last address/data presented to the SRAM, so the bus stays quiet between
    // accesses instead of following newly latched requests early.
    logic [ADDR_W-1:0] last_addr_q,  last_addr_d;
    logic [31:0]       last_wdata_q, last_wdata_d;

    // Byte-offset bits and address bits above the SRAM are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_addr_d   = req_addr_q;
        req_we_d     = req_we_q;
        req_sel_d    = req_sel_q;
        req_data_d   = req_data_q;
        rdata_d      = rdata_q;
        last_addr_d  = last_addr_q;
        last_wdata_d = last_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (ram_en_i) begin
                    req_addr_d = mem_addr_i[ADDR_W+1:2];
                    req_we_d   = mem_write_en_i;
                    req_sel_d  = mem_select_i;
                    req_data_d = store_data_i;
                    // A store with no lanes selected was misaligned; MEM has
                    // already flagged it, so just complete without touching SRAM.
                    if (mem_write_en_i && (mem_select_i == 4'b0000)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                last_addr_d  = req_addr_q;
                last_wdata_d = req_data_q;
                if (req_we_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                // Counter reaching zero marks the cycle the SRAM data is valid.
                if (cnt_q == 4'd0) begin
                    rdata_d = sram_rdata_i;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            req_addr_q   <= '0;
            req_we_q     <= 1'b0;
            req_sel_q    <= 4'b0000;
            req_data_q   <= 32'd0;
            rdata_q      <= 32'd0;
            last_addr_q  <= '0;
            last_wdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_addr_q   <= req_addr_d;
            req_we_q     <= req_we_d;
            req_sel_q    <= req_sel_d;
            req_data_q   <= req_data_d;
            rdata_q      <= rdata_d;
            last_addr_q  <= last_addr_d;
            last_wdata_q <= last_wdata_d;
        end
    end

    logic in_issue;
    assign in_issue = (state_q == ST_ISSUE);

    assign sram_en_o    = in_issue;
    assign sram_we_o    = (in_issue && req_we_q) ? req_sel_q : 4'b0000;
    assign sram_addr_o  = in_issue ? req_addr_q : last_addr_q;
    assign sram_wdata_o = in_issue ? req_data_q : last_wdata_q;

    assign ram_data_o   = rdata_q;
    assign stall_o      = ram_en_i && (state_q != ST_DONE);

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb/tb_data_ram_ctrl.sv - directed self-checking bench for data_ram_ctrl

module tb_data_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en0, ram_en3;
    logic        wr_en;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] sdata;

    logic [31:0] ram_data0, ram_data3;
    logic        stall0, stall3;
    logic        en0, en3;
    logic [3:0]  we0, we3;
    logic [15:0] saddr0, saddr3;
    logic [31:0] swdata0, swdata3;
    logic [31:0] srdata0, srdata3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_ram_ctrl #(.ADDR_W(16), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .ram_en_i(ram_en0), .mem_write_en_i(wr_en),
        .mem_addr_i(addr), .mem_select_i(sel), .store_data_i(sdata),
        .ram_data_o(ram_data0), .stall_o(stall0), .sram_en_o(en0), .sram_we_o(we0),
        .sram_addr_o(saddr0), .sram_wdata_o(swdata0), .sram_rdata_i(srdata0)
    );

    data_ram_ctrl #(.ADDR_W(16), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .ram_en_i(ram_en3), .mem_write_en_i(wr_en),
        .mem_addr_i(addr), .mem_select_i(sel), .store_data_i(sdata),
        .ram_data_o(ram_data3), .stall_o(stall3), .sram_en_o(en3), .sram_we_o(we3),
        .sram_addr_o(saddr3), .sram_wdata_o(swdata3), .sram_rdata_i(srdata3)
    );

    // SRAM models: data becomes valid k cycles after the enable cycle, where
    // k = latency; before that the bus carries recognisable garbage.
    logic [31:0] mem0 [256];
    logic [31:0] mem3 [256];
    logic [31:0] hold0, hold3;
    int          k0 = 0, k3 = 0;
    int          en3_cnt = 0;

    always @(posedge clk) begin
        if (en0) begin
            if (we0 != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (we0[b]) mem0[saddr0[7:0]][8*b +: 8] <= swdata0[8*b +: 8];
            end else begin
                hold0 <= mem0[saddr0[7:0]];
                k0    <= 1;
            end
        end else if (k0 > 0 && k0 < 20) begin
            k0 <= k0 + 1;
        end
    end

    always @(posedge clk) begin
        if (en3) begin
            en3_cnt <= en3_cnt + 1;
            if (we3 != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (we3[b]) mem3[saddr3[7:0]][8*b +: 8] <= swdata3[8*b +: 8];
            end else begin
                hold3 <= mem3[saddr3[7:0]];
                k3    <= 1;
            end
        end else if (k3 > 0 && k3 < 20) begin
            k3 <= k3 + 1;
        end
    end

    assign srdata0 = (k0 >= 1) ? hold0 : 32'hBAD0BAD0;
    assign srdata3 = (k3 >= 4) ? hold3 : (32'hBADBAD00 | 32'(k3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one request to completion; call just after a rising edge.
    task automatic do_req(input bit use3, input bit we, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          output int stalls, output int ens, output logic [3:0] we_seen,
                          output logic [15:0] addr_seen, output logic [31:0] wd_seen,
                          output logic [31:0] rd, output bit done);
        stalls = 0; ens = 0; we_seen = 4'b0000; addr_seen = '0; wd_seen = '0; rd = '0; done = 0;
        wr_en = we; addr = a; sel = s; sdata = d;
        if (use3) ram_en3 = 1'b1; else ram_en0 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!(use3 ? stall3 : stall0)) begin
                done = 1;
                rd   = use3 ? ram_data3 : ram_data0;
                break;
            end
            stalls++;
            if (use3 ? en3 : en0) begin
                ens++;
                we_seen   = use3 ? we3 : we0;
                addr_seen = use3 ? saddr3 : saddr0;
                wd_seen   = use3 ? swdata3 : swdata0;
            end
        end
        @(posedge clk); #1;
        ram_en0 = 1'b0; ram_en3 = 1'b0;
    endtask

    int          st, en;
    logic [3:0]  wes;
    logic [15:0] as;
    logic [31:0] wds, rd;
    bit          dn;
    int          en_before;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'd0;
            mem3[i] = 32'd0;
        end
        mem3[8'h10] = 32'h13579BDF;
    end

    initial begin
        rst = 1'b1; ram_en0 = 1'b1; ram_en3 = 1'b0;
        wr_en = 1'b1; addr = 32'h0000_0104; sel = 4'hF; sdata = 32'h5555_AAAA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_en",    {31'd0, en0},  32'd0);
        chk("rst_we",    {28'd0, we0},  32'd0);
        chk("rst_addr",  {16'd0, saddr0}, 32'd0);
        chk("rst_wdata", swdata0,       32'd0);
        chk("rst_rdata", ram_data0,     32'd0);
        chk("rst_stall", {31'd0, stall0}, 32'd1);
        ram_en0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(0, 1, 32'h0000_0104, 4'hF, 32'hDEADBEEF, st, en, wes, as, wds, rd, dn);
        chk("st_done",   32'(dn), 32'd1);
        chk("st_stalls", 32'(st), 32'd2);
        chk("st_ens",    32'(en), 32'd1);
        chk("st_we",     {28'd0, wes}, 32'hF);
        chk("st_addr",   {16'd0, as},  32'h41);
        chk("st_wdata",  wds,          32'hDEADBEEF);

        do_req(0, 0, 32'h0000_0104, 4'hF, 32'h0, st, en, wes, as, wds, rd, dn);
        chk("ld_stalls", 32'(st), 32'd3);
        chk("ld_ens",    32'(en), 32'd1);
        chk("ld_we",     {28'd0, wes}, 32'h0);
        chk("ld_data",   rd,           32'hDEADBEEF);

        do_req(0, 1, 32'h0000_0105, 4'b0100, 32'h11111111, st, en, wes, as, wds, rd, dn);
        chk("bst_stalls", 32'(st), 32'd2);
        chk("bst_we",     {28'd0, wes}, 32'h4);
        chk("bst_addr",   {16'd0, as},  32'h41);
        do_req(0, 0, 32'h0000_0104, 4'hF, 32'h0, st, en, wes, as, wds, rd, dn);
        chk("bld_data",   rd,           32'hDE11BEEF);

        do_req(0, 1, 32'h0000_0106, 4'b0000, 32'h99999999, st, en, wes, as, wds, rd, dn);
        chk("mis_stalls", 32'(st), 32'd1);
        chk("mis_ens",    32'(en), 32'd0);
        chk("mis_rdata",  rd,      32'hDE11BEEF);
        do_req(0, 0, 32'h0000_0104, 4'hF, 32'h0, st, en, wes, as, wds, rd, dn);
        chk("mis_mem",    rd,      32'hDE11BEEF);

        do_req(1, 1, 32'h0000_0200, 4'hF, 32'hCAFEF00D, st, en, wes, as, wds, rd, dn);
        chk("w3_st_stalls", 32'(st), 32'd2);
        chk("w3_st_addr",   {16'd0, as}, 32'h80);
        do_req(1, 0, 32'h0000_0200, 4'hF, 32'h0, st, en, wes, as, wds, rd, dn);
        chk("w3_ld_stalls", 32'(st), 32'd6);
        chk("w3_ld_data",   rd,      32'hCAFEF00D);

        // Drop the request while in WAIT: access must still complete.
        en_before = en3_cnt;
        wr_en = 1'b0; addr = 32'h0000_0040; sel = 4'hF; ram_en3 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ram_en3 = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("drop_data",  ram_data3,              32'h13579BDF);
        chk("drop_ens",   32'(en3_cnt - en_before), 32'd1);
        chk("drop_stall", {31'd0, stall3},        32'd0);
        @(posedge clk); #1;
        do_req(1, 0, 32'h0000_0200, 4'hF, 32'h0, st, en, wes, as, wds, rd, dn);
        chk("drop_next_stalls", 32'(st), 32'd6);
        chk("drop_next_data",   rd,      32'hCAFEF00D);

        // Reset while in WAIT: abandoned, outputs zeroed on the next cycle.
        wr_en = 1'b0; addr = 32'h0000_0040; sel = 4'hF; ram_en3 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rw_rdata", ram_data3,       32'd0);
        chk("rw_en",    {31'd0, en3},    32'd0);
        chk("rw_we",    {28'd0, we3},    32'd0);
        chk("rw_addr",  {16'd0, saddr3}, 32'd0);
        chk("rw_wdata", swdata3,         32'd0);
        chk("rw_stall", {31'd0, stall3}, 32'd1);
        rst = 1'b0; ram_en3 = 1'b0;
        @(posedge clk); #1;
        do_req(1, 0, 32'h0000_0200, 4'hF, 32'h0, st, en, wes, as, wds, rd, dn);
        chk("rw_next_stalls", 32'(st), 32'd6);
        chk("rw_next_data",   rd,      32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_ram_ctrl.md
# data_ram_ctrl

- Data-side memory responder for the MEM stage.
- Accepts the MEM stage's word-address, byte-select, write-enable and RAM-enable request and runs it against a single-port synchronous SRAM with a configurable number of wait states.
- Holds the pipeline with `stall_o` until the access completes, then returns the full 32-bit read word.
- Byte-lane extraction, sign extension and LL/SC logic stay in the MEM stage.

## Interface
- `ADDR_W`, default 16: SRAM word-address width; `sram_addr_o = mem_addr_i[ADDR_W+1:2]`, and upper address bits are ignored.
- `WAIT_CYCLES`, default 0: extra SRAM read latency beyond 1 cycle, valid range 0..15.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `ram_en_i`  in  1  request valid from MEM; held stable while `stall_o`=1
- `mem_write_en_i`  in  1  1=store, 0=load
- `mem_addr_i`  in  32  byte address
- `mem_select_i`  in  4  byte lanes, big-endian: bit3 = data[31:24], bit0 = data[7:0]
- `store_data_i`  in  32  lane-replicated store data
- `ram_data_o`  out  32  read word, valid in DONE
- `stall_o`  out  1  pipeline hold
- `sram_en_o`  out  1  SRAM chip enable, one-cycle pulse
- `sram_we_o`  out  4  SRAM byte write enables, same lane mapping as `mem_select_i`
- `sram_addr_o`  out  ADDR_W  SRAM word address
- `sram_wdata_o`  out  32  SRAM write data
- `sram_rdata_i`  in  32  SRAM read data, valid `WAIT_CYCLES`+1 cycles after the `sram_en_o` cycle

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If `ram_en_i`=1: latch addr, we, select and data into request registers.
  - Store with `mem_select_i`=0000 (misaligned, already filtered by MEM) → DONE directly, with no SRAM activity.
  - Any other request → ISSUE.
- **ISSUE** (1 cycle)
  - Drives `sram_en_o`=1, `sram_addr_o` and `sram_wdata_o` from the request registers.
  - `sram_we_o` = latched select if store, else 0000.
  - Store → DONE. Load → WAIT with counter = `WAIT_CYCLES`.
- **WAIT**
  - Counter decrements each cycle.
  - When the counter is 0: capture `sram_rdata_i` into the read register and go to DONE.
  - WAIT therefore lasts `WAIT_CYCLES`+1 cycles.
- **DONE** (1 cycle)
  - `ram_data_o` = read register; stores leave it unchanged.
  - Next state is always IDLE; the MEM stage advances on this edge.
- **`stall_o`** (combinational) = `ram_en_i` && state≠DONE. No stall when idle with no request.
- **SRAM outputs outside ISSUE:** `sram_en_o`=0, `sram_we_o`=0000, and addr/wdata hold their last values.
- **Transaction completion:** once latched, a transaction always runs to DONE, even if `ram_en_i` drops mid-access. Writes are never aborted. In DONE with `ram_en_i`=0 the controller simply returns to IDLE.
- **Request changes:** changes on the request inputs while not IDLE are ignored.
- **Back-to-back requests:** a request present in the cycle after DONE is accepted from IDLE normally. There is no bubble requirement beyond the IDLE cycle.
- **Lane handling:** full words are always read; lane selection is the MEM stage's job. `sram_wdata_o` passes `store_data_i` through unmodified.

## Timing
- **Reset** (synchronous; `rst`=1 at a clock edge):
  - state → IDLE, counter → 0, request and read registers → 0.
  - `ram_data_o`=0, `sram_en_o`=0, `sram_we_o`=0000, `sram_addr_o`=0, `sram_wdata_o`=0.
  - `stall_o` follows its equation; with state IDLE it equals `ram_en_i`.
  - Reset mid-transaction abandons the access immediately. An SRAM write already pulsed in ISSUE is not undone.
- **Load accepted in IDLE at cycle t:**
  - ISSUE at t+1.
  - WAIT from t+2 to t+2+`WAIT_CYCLES`.
  - DONE at t+3+`WAIT_CYCLES`.
  - `stall_o`=1 for cycles t..t+2+W, i.e. 3+W stall cycles.
- **Store accepted at t:** ISSUE at t+1, DONE at t+2; 2 stall cycles.
- **Store with select 0000 accepted at t:** DONE at t+1; 1 stall cycle, `sram_en_o` never asserted.
- **Counter width:** 4 bits.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `ram_en_i`=1 → state IDLE, all SRAM outputs 0, `ram_data_o`=0.
- **Store word then load word**, `WAIT_CYCLES`=0: `mem_addr_i`=0x0000_0104, select 1111, data 0xDEADBEEF.
  - Store: `sram_addr_o`=0x41, `sram_we_o`=1111 for one cycle, 2 stall cycles.
  - Load from the same address: 3 stall cycles, `ram_data_o`=0xDEADBEEF in DONE.
- **Byte store to addr 0x105**, select 0100, data 0x11111111 → `sram_we_o`=0100. A subsequent load of 0x104 returns 0xDE11BEEF.
- **`WAIT_CYCLES`=3 load:** `stall_o` high for exactly 6 cycles. The SRAM model drives garbage until cycle 4 after `sram_en_o`; the captured value is correct.
- **Misaligned store**, select 0000: `sram_en_o` stays 0, 1 stall cycle, and memory contents are unchanged.
- **`ram_en_i` dropped in WAIT:** the access still completes to DONE and returns to IDLE. Reset asserted in WAIT → IDLE next cycle with outputs zeroed.
